// File: rtl/slice_pkg.sv
// Shared types and constants for the 2x2 polyphase slice controller.
// Banks are named <row parity><col parity>; E = even, O = odd.
package slice_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] BANK_EE = 2'd0;
  localparam logic [1:0] BANK_OE = 2'd1;
  localparam logic [1:0] BANK_EO = 2'd2;
  localparam logic [1:0] BANK_OO = 2'd3;

  localparam int DEF_LAYER_NUM  = 1;
  localparam int DEF_WIDTH_IN   = 160;
  localparam int DEF_WIDTH_OUT  = 80;
  localparam int DEF_WIDTH_EACH = 16;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slice_addr_cnt.sv
// Raster column/row/layer counters and the bank address/select they imply.
// The address is built incrementally: a row base that steps by one output row per input row pair.
module slice_addr_cnt
  import slice_pkg::*;
#(
  parameter int LAYER_num      = DEF_LAYER_NUM,
  parameter int WIDTH_in_data  = DEF_WIDTH_IN,
  parameter int WIDTH_out_data = DEF_WIDTH_OUT,
  parameter int ADDR_W         = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        bank,
  output logic              last
);

  localparam int COL_W = clog2_min1(WIDTH_in_data);
  localparam int LAY_W = clog2_min1(LAYER_num);

  logic [COL_W-1:0]  col_q, col_d;
  logic [COL_W-1:0]  row_q, row_d;
  logic [LAY_W-1:0]  layer_q, layer_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              col_end, row_end, layer_end;

  assign col_end   = (col_q == COL_W'(WIDTH_in_data - 1));
  assign row_end   = (row_q == COL_W'(WIDTH_in_data - 1));
  assign layer_end = (layer_q == LAY_W'(LAYER_num - 1));

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    layer_d    = layer_q;
    row_base_d = row_base_q;
    if (clr) begin
      col_d      = '0;
      row_d      = '0;
      layer_d    = '0;
      row_base_d = '0;
    end else if (adv) begin
      if (col_end) begin
        col_d = '0;
        // Finishing an odd row closes an output row; the last row of a layer
        // lands the base exactly on the next layer's start.
        if (row_q[0]) begin
          row_base_d = row_base_q + ADDR_W'(WIDTH_out_data);
        end
        if (row_end) begin
          row_d   = '0;
          layer_d = layer_end ? '0 : layer_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      layer_q    <= '0;
      row_base_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      layer_q    <= layer_d;
      row_base_q <= row_base_d;
    end
  end

  assign addr = row_base_q + ADDR_W'(col_q >> 1);
  assign bank = {col_q[0], row_q[0]};
  assign last = col_end && row_end && layer_end;

endmodule

// File: rtl/slice_ctrl.sv
// Frame controller: accepts a raster feature map and scatters it into four
// half-resolution banks by (row, col) parity, with registered write outputs.
module slice_ctrl
  import slice_pkg::*;
#(
  parameter int   LAYER_num       = DEF_LAYER_NUM,
  parameter int   WIDTH_in_data   = DEF_WIDTH_IN,
  parameter int   WIDTH_out_data  = DEF_WIDTH_OUT,
  parameter int   WIDTH_each_data = DEF_WIDTH_EACH,
  localparam int  ADDR_W          = clog2_min1(LAYER_num * WIDTH_out_data * WIDTH_out_data)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [WIDTH_each_data-1:0] in_data,
  output logic                       in_ready,
  output logic [3:0]                 wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [WIDTH_each_data-1:0] wr_data,
  output logic                       busy,
  output logic                       done
);

  state_t state_q, state_d;

  logic                       hs;
  logic                       enter_run;
  logic [ADDR_W-1:0]          cnt_addr;
  logic [1:0]                 cnt_bank;
  logic                       cnt_last;

  logic [3:0]                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic [WIDTH_each_data-1:0] wr_data_q, wr_data_d;
  logic                       done_q;

  assign in_ready  = (state_q == S_RUN);
  assign hs        = in_valid && in_ready;
  assign enter_run = (state_q == S_IDLE) && start;

  slice_addr_cnt #(
    .LAYER_num      (LAYER_num),
    .WIDTH_in_data  (WIDTH_in_data),
    .WIDTH_out_data (WIDTH_out_data),
    .ADDR_W         (ADDR_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (enter_run),
    .adv  (hs),
    .addr (cnt_addr),
    .bank (cnt_bank),
    .last (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (hs && cnt_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
    assign wr_en_d[gi] = hs && (cnt_bank == 2'(gi));
  end

  assign wr_addr_d = hs ? cnt_addr : wr_addr_q;
  assign wr_data_d = hs ? in_data  : wr_data_q;

  // done trails the DONE state by a cycle so it follows the final strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= (state_q == S_DONE);
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q == S_RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_slice_ctrl.sv
// Directed bench: 4x4 single-layer table, 4x4 two-layer frame, full default frame.
module tb_slice_ctrl;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  en;
    logic [1:0]  addr;
  } vec_t;

  vec_t vtab [16];

  int vec_cnt     = 0;
  int miscompares = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 1 layer, 4x4 -> 2x2
  logic        start_a, valid_a, ready_a, busy_a, done_a;
  logic [15:0] data_a, wr_data_a;
  logic [3:0]  wr_en_a;
  logic [1:0]  wr_addr_a;

  // DUT B: 2 layers, 4x4 -> 2x2
  logic        start_b, valid_b, ready_b, busy_b, done_b;
  logic [15:0] data_b, wr_data_b;
  logic [3:0]  wr_en_b;
  logic [2:0]  wr_addr_b;

  // DUT C: defaults, 160x160 -> 80x80
  logic        start_c, valid_c, ready_c, busy_c, done_c;
  logic [15:0] data_c, wr_data_c;
  logic [3:0]  wr_en_c;
  logic [12:0] wr_addr_c;

  slice_ctrl #(.LAYER_num(1), .WIDTH_in_data(4), .WIDTH_out_data(2), .WIDTH_each_data(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_data(data_a),
    .in_ready(ready_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .done(done_a)
  );

  slice_ctrl #(.LAYER_num(2), .WIDTH_in_data(4), .WIDTH_out_data(2), .WIDTH_each_data(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_data(data_b),
    .in_ready(ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .done(done_b)
  );

  slice_ctrl dut_c (
    .clk(clk), .rst(rst), .start(start_c), .in_valid(valid_c), .in_data(data_c),
    .in_ready(ready_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .busy(busy_c), .done(done_c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Independent reference placement for any element index.
  task automatic exp_wr(input int d, input int in_w, input int out_w, output int bank, output int addr);
    int l, r, c;
    l    = d / (in_w * in_w);
    r    = (d / in_w) % in_w;
    c    = d % in_w;
    bank = (c % 2) * 2 + (r % 2);
    addr = l * out_w * out_w + (r / 2) * out_w + c / 2;
  endtask

  int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (done_c) done_cnt_c++;
  end

  int          eb_b, ea_b, eb_c, ea_c;
  int          cnt_b [4];
  int          cnt_c [4];
  bit          seen_b [32];
  bit          seen_c [25600];
  logic [3:0]  e16_en, e31_en;
  logic [2:0]  e16_addr, e31_addr;
  logic [12:0] last_addr3_c;
  logic [15:0] last_data3_c;

  initial begin
    for (int k = 0; k < 4; k++) begin
      cnt_b[k] = 0;
      cnt_c[k] = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && wr_en_b != 4'b0) begin
      exp_wr(int'(wr_data_b), 4, 2, eb_b, ea_b);
      chk("b_wr_en", {28'b0, wr_en_b}, 32'(1 << eb_b));
      chk("b_wr_addr", {29'b0, wr_addr_b}, 32'(ea_b));
      chk("b_dup", {31'b0, seen_b[eb_b * 8 + ea_b]}, 32'd0);
      seen_b[eb_b * 8 + ea_b] = 1'b1;
      cnt_b[eb_b]++;
      if (wr_data_b == 16'd16) begin e16_en = wr_en_b; e16_addr = wr_addr_b; end
      if (wr_data_b == 16'd31) begin e31_en = wr_en_b; e31_addr = wr_addr_b; end
    end
  end

  always @(negedge clk) begin
    if (!rst && wr_en_c != 4'b0) begin
      exp_wr(int'(wr_data_c), 160, 80, eb_c, ea_c);
      chk("c_wr_en", {28'b0, wr_en_c}, 32'(1 << eb_c));
      chk("c_wr_addr", {19'b0, wr_addr_c}, 32'(ea_c));
      chk("c_dup", {31'b0, seen_c[eb_c * 6400 + ea_c]}, 32'd0);
      seen_c[eb_c * 6400 + ea_c] = 1'b1;
      cnt_c[eb_c]++;
      if (wr_en_c[3]) begin last_addr3_c = wr_addr_c; last_data3_c = wr_data_c; end
    end
  end

  task automatic start_a_frame();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("a_busy_after_start", {31'b0, busy_a}, 32'd1);
    chk("a_ready_after_start", {31'b0, ready_a}, 32'd1);
  endtask

  task automatic feed_a(input int i, input bit with_start);
    data_a  = vtab[i].data;
    valid_a = 1'b1;
    start_a = with_start;
    @(posedge clk); #1;
    valid_a = 1'b0;
    start_a = 1'b0;
    chk($sformatf("a_wr_en[%0d]", i), {28'b0, wr_en_a}, {28'b0, vtab[i].en});
    chk($sformatf("a_wr_addr[%0d]", i), {30'b0, wr_addr_a}, {30'b0, vtab[i].addr});
    chk($sformatf("a_wr_data[%0d]", i), {16'b0, wr_data_a}, {16'b0, vtab[i].data});
  endtask

  task automatic gap_a();
    @(posedge clk); #1;
    chk("a_gap_wr_en", {28'b0, wr_en_a}, 32'd0);
    chk("a_gap_busy", {31'b0, busy_a}, 32'd1);
  endtask

  task automatic end_a_frame(input int exp_done);
    chk("a_done_with_last_wr", {31'b0, done_a}, 32'd0);
    @(posedge clk); #1;
    chk("a_done_pulse", {31'b0, done_a}, 32'd1);
    chk("a_wr_en_at_done", {28'b0, wr_en_a}, 32'd0);
    @(posedge clk); #1;
    chk("a_done_cleared", {31'b0, done_a}, 32'd0);
    chk("a_busy_idle", {31'b0, busy_a}, 32'd0);
    chk("a_ready_idle", {31'b0, ready_a}, 32'd0);
    chk("a_done_count", 32'(done_cnt_a), 32'(exp_done));
  endtask

  initial begin
    vtab[0]  = '{16'd0,  4'b0001, 2'd0};
    vtab[1]  = '{16'd1,  4'b0100, 2'd0};
    vtab[2]  = '{16'd2,  4'b0001, 2'd1};
    vtab[3]  = '{16'd3,  4'b0100, 2'd1};
    vtab[4]  = '{16'd4,  4'b0010, 2'd0};
    vtab[5]  = '{16'd5,  4'b1000, 2'd0};
    vtab[6]  = '{16'd6,  4'b0010, 2'd1};
    vtab[7]  = '{16'd7,  4'b1000, 2'd1};
    vtab[8]  = '{16'd8,  4'b0001, 2'd2};
    vtab[9]  = '{16'd9,  4'b0100, 2'd2};
    vtab[10] = '{16'd10, 4'b0001, 2'd3};
    vtab[11] = '{16'd11, 4'b0100, 2'd3};
    vtab[12] = '{16'd12, 4'b0010, 2'd2};
    vtab[13] = '{16'd13, 4'b1000, 2'd2};
    vtab[14] = '{16'd14, 4'b0010, 2'd3};
    vtab[15] = '{16'd15, 4'b1000, 2'd3};

    rst = 1'b1;
    start_a = 1'b0; valid_a = 1'b0; data_a = '0;
    start_b = 1'b0; valid_b = 1'b0; data_b = '0;
    start_c = 1'b0; valid_c = 1'b0; data_c = '0;

    #2;
    chk("rst_wr_en", {28'b0, wr_en_a}, 32'd0);
    chk("rst_wr_addr", {30'b0, wr_addr_a}, 32'd0);
    chk("rst_wr_data", {16'b0, wr_data_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_ready", {31'b0, ready_a}, 32'd0);
    chk("rst_b_c_wr_en", {24'b0, wr_en_b, wr_en_c}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back frame
    start_a_frame();
    for (int i = 0; i < 16; i++) feed_a(i, 1'b0);
    end_a_frame(1);

    // in_valid low every other cycle
    start_a_frame();
    for (int i = 0; i < 16; i++) begin
      feed_a(i, 1'b0);
      if (i < 15) gap_a();
    end
    end_a_frame(2);

    // start re-pulsed mid-frame is ignored
    start_a_frame();
    for (int i = 0; i < 16; i++) feed_a(i, i == 5);
    end_a_frame(3);

    // Asynchronous reset after element 9 aborts the frame
    start_a_frame();
    for (int i = 0; i < 10; i++) feed_a(i, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_en", {28'b0, wr_en_a}, 32'd0);
    chk("arst_wr_addr", {30'b0, wr_addr_a}, 32'd0);
    chk("arst_wr_data", {16'b0, wr_data_a}, 32'd0);
    chk("arst_busy", {31'b0, busy_a}, 32'd0);
    chk("arst_ready", {31'b0, ready_a}, 32'd0);
    chk("arst_done", {31'b0, done_a}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_done", 32'(done_cnt_a), 32'd3);
    chk("arst_idle_after", {31'b0, busy_a}, 32'd0);
    start_a_frame();
    for (int i = 0; i < 16; i++) feed_a(i, 1'b0);
    end_a_frame(4);

    // Two-layer frame
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      data_b  = 16'(i);
      valid_b = 1'b1;
      @(posedge clk); #1;
    end
    valid_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b_e16_en", {28'b0, e16_en}, 32'b0001);
    chk("b_e16_addr", {29'b0, e16_addr}, 32'd4);
    chk("b_e31_en", {28'b0, e31_en}, 32'b1000);
    chk("b_e31_addr", {29'b0, e31_addr}, 32'd7);
    for (int k = 0; k < 4; k++) chk($sformatf("b_bank%0d_writes", k), 32'(cnt_b[k]), 32'd8);
    chk("b_done_count", 32'(done_cnt_b), 32'd1);

    // Full default-size frame
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    for (int i = 0; i < 25600; i++) begin
      data_c  = 16'(i);
      valid_c = 1'b1;
      @(posedge clk); #1;
    end
    valid_c = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("c_bank%0d_writes", k), 32'(cnt_c[k]), 32'd6400);
    chk("c_bank3_last_addr", {19'b0, last_addr3_c}, 32'd6399);
    chk("c_bank3_last_data", {16'b0, last_data3_c}, 32'd25599);
    chk("c_done_count", 32'(done_cnt_c), 32'd1);
    chk("c_idle_after", {31'b0, busy_c}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
